gbn_arq_tx: RTL

//  Go-Back-N ARQ transmitter; generalises the stop-and-wait controller to a window of WIN_SIZE frames.
//  - Buffers accepted payloads and appends a sequence number and a CRC to each.
//  - Streams frames to the link and retires them on cumulative ACKs.
//  - On timeout (or NAK) it rewinds to the oldest unacked frame.
//  - Sits between the payload source and the link serializer.

---
 rtl/arq_pkg.sv | 39 +++
 rtl/arq_tx_buf.sv | 41 ++++
 rtl/gbn_arq_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/arq_pkg.sv
// Shared Go-Back-N ARQ definitions: FSM encoding, default widths, frame field
// offsets and the CRC routine also used by the receiver.
package arq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arq_state_e;

  localparam int unsigned ARQ_PAYLOAD_BW = 10;
  localparam int unsigned ARQ_CRC_BW     = 8;
  localparam int unsigned ARQ_SEQ_BW     = 3;
  localparam int unsigned ARQ_WIN_SIZE   = 4;
  localparam int unsigned ARQ_CNT_BW     = 5;
  localparam logic [7:0]  ARQ_CRC_POLY   = 8'h07;

  // Frame layout {seq, payload, crc}, LSB offsets for the default widths
  localparam int unsigned FRM_CRC_LSB = 0;
  localparam int unsigned FRM_PAY_LSB = ARQ_CRC_BW;
  localparam int unsigned FRM_SEQ_LSB = ARQ_CRC_BW + ARQ_PAYLOAD_BW;

  // MSB-first CRC over the low data_bw bits of data; init 0, no reflection, no final XOR
  function automatic logic [31:0] crc_calc(input logic [63:0] data, input int unsigned data_bw,
                                           input int unsigned crc_bw, input logic [31:0] poly);
    logic [31:0] crc;
    logic        fb;
    crc = '0;
    for (int i = 63; i >= 0; i--) begin
      if (i < int'(data_bw)) begin
        fb  = crc[5'(crc_bw - 1)] ^ data[6'(i)];
        crc = crc << 1;
        if (fb) crc = crc ^ poly;
      end
    end
    return crc & ((32'h1 << crc_bw) - 32'h1);
  endfunction

endpackage

// File: rtl/arq_tx_buf.sv
// Frame store for the ARQ transmitter: DEPTH x DATA_BW registers, one write
// port, one registered read port with write-through on an address collision.
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write slot
//   wr_data  : frame to store
//   rd_addr  : slot to present on the next cycle
//   rd_data  : registered read data
module arq_tx_buf #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_BW = 21,
  parameter int unsigned ADDR_BW = 2
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_BW-1:0] wr_addr,
  input  logic [DATA_BW-1:0] wr_data,
  input  logic [ADDR_BW-1:0] rd_addr,
  output logic [DATA_BW-1:0] rd_data
);

  logic [DATA_BW-1:0] mem_q [DEPTH];
  logic [DATA_BW-1:0] mem_d [DEPTH];
  logic [DATA_BW-1:0] rd_data_q, rd_data_d;

  // Reading from mem_d makes a same-cycle write visible at the read port
  always_comb begin : buf_next
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
    rd_data_d = mem_d[rd_addr];
  end

  // Contents are don't-care after reset, so the array carries no reset
  always_ff @(posedge clk) begin
    mem_q     <= mem_d;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gbn_arq_tx.sv
// Go-Back-N ARQ transmitter: buffers up to WIN_SIZE payloads as
// {seq, payload, crc} frames, streams them to the link, retires them on
// cumulative ACKs and rewinds to the oldest unacked frame on timeout.
// Optional feature macro ARQ_NAK_EN adds input ack_nak for immediate rewind.
//   clk, rstn                  : clock, synchronous active-low reset
//   payload/_valid/_ready      : payload intake (ready = window not full)
//   frame/_valid/_ready        : frame output to the link serializer
//   ack_valid, ack_num         : cumulative ACK (next seq expected)
//   ack_nak                    : ACK is a NAK (ARQ_NAK_EN only)
//   ack_err                    : one-cycle pulse on an out-of-window ACK
//   retx_cnt                   : saturating count of go-back events
module gbn_arq_tx
  import arq_pkg::*;
#(
  parameter int unsigned       PAYLOAD_BW = ARQ_PAYLOAD_BW,
  parameter int unsigned       CRC_BW     = ARQ_CRC_BW,
  parameter logic [CRC_BW-1:0] CRC_POLY   = CRC_BW'(ARQ_CRC_POLY),
  parameter int unsigned       SEQ_BW     = ARQ_SEQ_BW,
  parameter int unsigned       WIN_SIZE   = ARQ_WIN_SIZE,
  parameter int unsigned       CNT_BW     = ARQ_CNT_BW
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [PAYLOAD_BW-1:0]              payload,
  input  logic                               payload_valid,
  output logic                               payload_ready,
  output logic [SEQ_BW+PAYLOAD_BW+CRC_BW-1:0] frame,
  output logic                               frame_valid,
  input  logic                               frame_ready,
  input  logic                               ack_valid,
  input  logic [SEQ_BW-1:0]                  ack_num,
`ifdef ARQ_NAK_EN
  input  logic                               ack_nak,
`endif
  output logic                               ack_err,
  output logic [7:0]                         retx_cnt
);

  localparam int unsigned FRAME_BW = SEQ_BW + PAYLOAD_BW + CRC_BW;
  localparam int unsigned ADDR_BW  = (WIN_SIZE > 1) ? $clog2(WIN_SIZE) : 1;
  localparam logic [SEQ_BW-1:0] WIN_SEQ = SEQ_BW'(WIN_SIZE);
  localparam logic [CNT_BW-1:0] TMO_VAL = '1;

  if ((WIN_SIZE == 0) || (WIN_SIZE >= (1 << SEQ_BW))) begin : g_bad_win
    $error("gbn_arq_tx: WIN_SIZE must be in 1..2**SEQ_BW-1");
  end

  arq_state_e          state_q, state_d;
  logic [SEQ_BW-1:0]   base_q, base_d, send_ptr_q, send_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_BW-1:0]   timer_q, timer_d;
  logic [7:0]          retx_q, retx_d, retx_inc;
  logic                frame_valid_q, frame_valid_d;
  logic                ack_err_q, ack_err_d;
  logic                payload_ready_q, payload_ready_d;

  logic                accept, send_hs, ack_ok, nak_ok, timing_on, timeout;
  logic [SEQ_BW-1:0]   ack_dist, out_dist, stored_d;
  logic [CRC_BW-1:0]   wr_crc;
  logic [ADDR_BW-1:0]  wr_slot, rd_slot;

  // Event decode on pre-cycle state; an ACK is in-window when it lies in (base, send_ptr]
  always_comb begin : event_decode
    accept    = payload_valid & payload_ready_q;
    send_hs   = frame_valid_q & frame_ready;
    ack_dist  = ack_num - base_q;
    out_dist  = send_ptr_q - base_q;
    ack_ok    = ack_valid && (ack_dist != '0) && (ack_dist <= out_dist);
`ifdef ARQ_NAK_EN
    nak_ok    = ack_ok & ack_nak;
`else
    nak_ok    = 1'b0;
`endif
    timing_on = (base_q != send_ptr_q) && (state_q != ST_IDLE);
    timeout   = timing_on && (timer_q == TMO_VAL);
    retx_inc  = (retx_q == 8'hFF) ? retx_q : retx_q + 8'd1;
    wr_crc    = CRC_BW'(crc_calc(64'({wr_ptr_q, payload}), SEQ_BW + PAYLOAD_BW, CRC_BW,
                                 32'(CRC_POLY)));
    wr_slot   = ADDR_BW'(wr_ptr_q % WIN_SEQ);
  end

  // Pointer, timer and counter update; a valid ACK overrides a same-cycle timeout
  always_comb begin : ctrl_next
    base_d     = base_q;
    send_ptr_d = send_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    timer_d    = timer_q;
    retx_d     = retx_q;
    if (accept)  wr_ptr_d   = wr_ptr_q + SEQ_BW'(1);
    if (send_hs) send_ptr_d = send_ptr_q + SEQ_BW'(1);
    if (timing_on) timer_d = timer_q + CNT_BW'(1);
    if (send_hs && (base_q == send_ptr_q)) timer_d = '0;
    if (ack_ok) begin
      base_d  = ack_num;
      timer_d = '0;
      if (nak_ok) begin
        send_ptr_d = ack_num;
        retx_d     = retx_inc;
      end
    end else if (timeout) begin
      // Rewind wins over a same-cycle handshake
      send_ptr_d = base_q;
      timer_d    = '0;
      retx_d     = retx_inc;
    end
    ack_err_d       = ack_valid & ~ack_ok;
    frame_valid_d   = (send_ptr_d != wr_ptr_d);
    stored_d        = wr_ptr_d - base_d;
    payload_ready_d = (stored_d < WIN_SEQ);
    rd_slot         = ADDR_BW'(send_ptr_d % WIN_SEQ);
  end

  // FSM: IDLE when nothing stored, SEND while unsent frames remain, else WAIT
  always_comb begin : fsm_next
    state_d = state_q;
    if (wr_ptr_d == base_d)          state_d = ST_IDLE;
    else if (send_ptr_d != wr_ptr_d) state_d = ST_SEND;
    else                             state_d = ST_WAIT;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      send_ptr_q      <= '0;
      wr_ptr_q        <= '0;
      timer_q         <= '0;
      retx_q          <= '0;
      frame_valid_q   <= 1'b0;
      ack_err_q       <= 1'b0;
      payload_ready_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      send_ptr_q      <= send_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      timer_q         <= timer_d;
      retx_q          <= retx_d;
      frame_valid_q   <= frame_valid_d;
      ack_err_q       <= ack_err_d;
      payload_ready_q <= payload_ready_d;
    end
  end

  arq_tx_buf #(
    .DEPTH   (WIN_SIZE),
    .DATA_BW (FRAME_BW),
    .ADDR_BW (ADDR_BW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_slot),
    .wr_data ({wr_ptr_q, payload, wr_crc}),
    .rd_addr (rd_slot),
    .rd_data (frame)
  );

  assign frame_valid   = frame_valid_q;
  assign ack_err       = ack_err_q;
  assign payload_ready = payload_ready_q;
  assign retx_cnt      = retx_q;

endmodule
